// File: rtl/pipelined_cla_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_cla_adder
// Brief    : Pipelined 4-bit-group carry look-ahead adder/subtractor with
//            valid/ready handshakes and signed overflow flag.
// Revision : 1.0
// ============================================================================
module pipelined_cla_adder #(
  parameter int WIDTH        = 20,
  parameter int STAGE_BLOCKS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int c_groups = WIDTH / 4;
  localparam int c_stages = (c_groups + STAGE_BLOCKS - 1) / STAGE_BLOCKS;

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 4 || WIDTH > 64) begin : g_bad_width
      $error("pipelined_cla_adder: WIDTH must be a multiple of 4 in 4..64");
    end
    if (STAGE_BLOCKS < 1) begin : g_bad_blocks
      $error("pipelined_cla_adder: STAGE_BLOCKS must be at least 1");
    end
  endgenerate

  // Returns {carry into bit 3, carry out, 4-bit sum}.
  function automatic logic [5:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                      input logic ci);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = x & y;
    p    = x ^ y;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return {c[3], c[4], p ^ c[3:0]};
  endfunction

  // r_x holds finished sum bits below the processed boundary and raw a bits above it.
  logic [WIDTH-1:0] r_x [c_stages];
  logic [WIDTH-1:0] r_y [c_stages];
  logic             r_c [c_stages];
  logic             r_v [c_stages];
  logic             r_ovf;

  logic [WIDTH-1:0] w_x_in  [c_stages];
  logic [WIDTH-1:0] w_y_in  [c_stages];
  logic [WIDTH-1:0] w_x_out [c_stages];
  logic             w_c_in  [c_stages];
  logic             w_c_out [c_stages];
  logic             w_ovf;
  logic             w_en;
  logic             w_unused;

  assign w_en = ~r_v[c_stages-1] | out_ready;

  always_comb begin
    logic       c;
    logic [5:0] grp;
    c     = 1'b0;
    grp   = '0;
    w_ovf = 1'b0;
    w_x_in[0] = a;
    w_y_in[0] = sub ? ~b : b;
    w_c_in[0] = cin ^ sub;
    for (int j = 1; j < c_stages; j++) begin
      w_x_in[j] = r_x[j-1];
      w_y_in[j] = r_y[j-1];
      w_c_in[j] = r_c[j-1];
    end
    for (int j = 0; j < c_stages; j++) begin
      w_x_out[j] = w_x_in[j];
      c          = w_c_in[j];
      for (int k = 0; k < c_groups; k++) begin
        if ((k / STAGE_BLOCKS) == j) begin
          grp                 = cla4(w_x_in[j][4*k +: 4], w_y_in[j][4*k +: 4], c);
          w_x_out[j][4*k +: 4] = grp[3:0];
          c                   = grp[4];
          if (k == c_groups - 1) begin
            w_ovf = grp[5] ^ grp[4];
          end
        end
      end
      w_c_out[j] = c;
    end
  end

  // Operand bits already consumed by earlier stages are never read downstream.
  always_comb begin
    w_unused = 1'b0;
    for (int j = 0; j < c_stages; j++) begin
      w_unused = w_unused ^ (^r_y[j]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < c_stages; j++) begin
        r_x[j] <= '0;
        r_y[j] <= '0;
        r_c[j] <= 1'b0;
        r_v[j] <= 1'b0;
      end
      r_ovf <= 1'b0;
    end else if (w_en) begin
      r_v[0] <= in_valid;
      for (int j = 1; j < c_stages; j++) begin
        r_v[j] <= r_v[j-1];
      end
      for (int j = 0; j < c_stages; j++) begin
        r_x[j] <= w_x_out[j];
        r_y[j] <= w_y_in[j];
        r_c[j] <= w_c_out[j];
      end
      r_ovf <= w_ovf;
    end
  end

  assign in_ready  = w_en;
  assign out_valid = r_v[c_stages-1];
  assign sum       = r_x[c_stages-1];
  assign cout      = r_c[c_stages-1];
  assign overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_cla_adder.sv
`default_nettype none
// Self-checking bench for pipelined_cla_adder: default instance with a
// scoreboard, plus a bank of parameter-sweep instances.
module tb_pipelined_cla_adder;

  typedef struct packed {
    logic [19:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] a;
  logic [19:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] sum;
  logic        cout;
  logic        overflow;

  int   checks   = 0;
  int   failures = 0;
  int   n_out    = 0;
  exp_t pend;
  exp_t q[$];
  logic        hold_prev = 1'b0;
  logic [19:0] h_sum;
  logic        h_cout;
  logic        h_ovf;

  pipelined_cla_adder #(.WIDTH(20), .STAGE_BLOCKS(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .overflow(overflow)
  );

  // Sweep bank: all instances share one stimulus bus and always accept output.
  localparam int NC = 7;
  function automatic int cfg_w(input int i);
    case (i)
      0: return 4;
      1: return 8;
      2: return 8;
      3: return 20;
      4: return 64;
      5: return 64;
      default: return 64;
    endcase
  endfunction
  function automatic int cfg_sb(input int i);
    case (i)
      0: return 1;
      1: return 1;
      2: return 2;
      3: return 1;
      4: return 2;
      5: return 16;
      default: return 1;
    endcase
  endfunction

  logic [63:0]      sw_a;
  logic [63:0]      sw_b;
  logic             sw_cin;
  logic             sw_sub;
  logic             sw_in_valid;
  logic [NC-1:0]    sw_ready;
  logic [NC-1:0]    sw_valid;
  logic [NC*64-1:0] sw_sum;
  logic [NC-1:0]    sw_cout;
  logic [NC-1:0]    sw_ovf;

  generate
    for (genvar i = 0; i < NC; i++) begin : g_sw
      localparam int W  = cfg_w(i);
      localparam int SB = cfg_sb(i);
      logic [W-1:0] s;
      pipelined_cla_adder #(.WIDTH(W), .STAGE_BLOCKS(SB)) u_dut (
        .clk(clk), .rst(rst), .in_valid(sw_in_valid), .in_ready(sw_ready[i]),
        .a(sw_a[W-1:0]), .b(sw_b[W-1:0]), .cin(sw_cin), .sub(sw_sub),
        .out_valid(sw_valid[i]), .out_ready(1'b1),
        .sum(s), .cout(sw_cout[i]), .overflow(sw_ovf[i])
      );
      assign sw_sum[i*64 +: 64] = 64'(s);
    end
  endgenerate

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: {overflow, cout, sum} of a + (sub ? ~b : b) + (cin ^ sub) at width w.
  function automatic logic [65:0] model(input logic [63:0] xa, input logic [63:0] xb,
                                        input logic xcin, input logic xsub, input int w);
    logic [64:0] m;
    logic [64:0] full;
    logic [63:0] am;
    logic [63:0] bp;
    logic [63:0] s;
    logic        co;
    logic        ov;
    m    = (65'd1 << w) - 65'd1;
    am   = xa & m[63:0];
    bp   = (xsub ? ~xb : xb) & m[63:0];
    full = {1'b0, am} + {1'b0, bp} + 65'(xcin ^ xsub);
    s    = full[63:0] & m[63:0];
    co   = full[w];
    ov   = (am[w-1] == bp[w-1]) && (s[w-1] != am[w-1]);
    return {ov, co, s};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: sample/compare at the falling edge, record acceptance at the rising edge.
  task automatic cycle(output logic seen_out, output logic took_in);
    exp_t e;
    @(negedge clk);
    seen_out = (out_valid === 1'b1);
    took_in  = (in_valid === 1'b1) && (in_ready === 1'b1) && !rst;
    if (hold_prev && !rst) begin
      chk("stall_valid", 64'(out_valid), 64'(1'b1));
      chk("stall_sum", 64'(sum), 64'(h_sum));
      chk("stall_cout", 64'(cout), 64'(h_cout));
      chk("stall_ovf", 64'(overflow), 64'(h_ovf));
    end
    if (!rst && out_valid === 1'b1 && !out_ready) begin
      chk("stall_in_ready", 64'(in_ready), 64'(1'b0));
    end
    if (!rst && out_valid === 1'b1 && out_ready) begin
      checks++;
      assert (q.size() != 0) else begin
        failures++;
        $error("FAIL sb_underflow observed=output expected=none");
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("sum", 64'(sum), 64'(e.sum));
        chk("cout", 64'(cout), 64'(e.cout));
        chk("overflow", 64'(overflow), 64'(e.ovf));
        n_out++;
      end
    end
    hold_prev = !rst && (out_valid === 1'b1) && !out_ready;
    h_sum  = sum;
    h_cout = cout;
    h_ovf  = overflow;
    @(posedge clk);
    if (took_in) q.push_back(pend);
    #1;
  endtask

  task automatic do_one(input logic [19:0] xa, input logic [19:0] xb, input logic xcin,
                        input logic xsub, input logic [19:0] es, input logic ec,
                        input logic eo, input string tag);
    logic v;
    logic t;
    int   n;
    a = xa; b = xb; cin = xcin; sub = xsub;
    pend.sum = es; pend.cout = ec; pend.ovf = eo;
    in_valid = 1'b1; out_ready = 1'b1;
    cycle(v, t);
    chk({tag, "_accept"}, 64'(t), 64'(1'b1));
    in_valid = 1'b0;
    n = 0;
    v = 1'b0;
    while (!v && n < 10) begin
      cycle(v, t);
      if (!v) n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'd2);
    chk({tag, "_drained"}, 64'(q.size()), 64'd0);
  endtask

  initial begin
    logic        v;
    logic        t;
    logic [65:0] r;
    int          seen;
    int          sent;
    int          base;
    int          first [NC];
    logic [63:0] c_sum [NC];
    logic        c_co  [NC];
    logic        c_ov  [NC];

    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    a = 20'h12345; b = 20'h0ABCD; cin = 1'b1; sub = 1'b0;
    pend = '0;
    sw_a = '0; sw_b = '0; sw_cin = 1'b0; sw_sub = 1'b0; sw_in_valid = 1'b0;

    // Reset with a pending operand: nothing may be captured.
    cycle(v, t);
    cycle(v, t);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0; in_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(v, t);
      if (v) seen++;
    end
    chk("post_reset_idle", 64'(seen), 64'd0);

    // Directed operations, expected values taken straight from the arithmetic.
    do_one(20'hFFFFF, 20'h00001, 1'b0, 1'b0, 20'h00000, 1'b1, 1'b0, "ripple");
    do_one(20'h00005, 20'h00007, 1'b0, 1'b1, 20'hFFFFE, 1'b0, 1'b0, "sub_neg");
    do_one(20'h00007, 20'h00005, 1'b1, 1'b1, 20'h00001, 1'b1, 1'b0, "sub_borrow");
    do_one(20'h7FFFF, 20'h00001, 1'b0, 1'b0, 20'h80000, 1'b0, 1'b1, "ovf_add");
    do_one(20'h80000, 20'h00001, 1'b0, 1'b1, 20'h7FFFF, 1'b1, 1'b1, "ovf_sub");

    // Random stream with randomised in_valid / out_ready.
    sent = 0;
    base = n_out;
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 400 && (sent < 16 || q.size() != 0); cyc++) begin
      if (!in_valid && sent < 16 && $urandom_range(0, 3) != 0) begin
        a = 20'($urandom); b = 20'($urandom);
        cin = 1'($urandom); sub = 1'($urandom);
        r = model({44'd0, a}, {44'd0, b}, cin, sub, 20);
        pend.sum = r[19:0]; pend.cout = r[64]; pend.ovf = r[65];
        in_valid = 1'b1;
      end
      out_ready = (sent >= 16) ? 1'b1 : ($urandom_range(0, 2) != 0);
      cycle(v, t);
      if (t) begin
        sent++;
        in_valid = 1'b0;
      end
    end
    chk("stream_sent", 64'(sent), 64'd16);
    chk("stream_received", 64'(n_out - base), 64'd16);
    chk("stream_queue_empty", 64'(q.size()), 64'd0);

    // Mid-stream reset with three transactions held in the pipe.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = 20'(i + 1); b = 20'h00010; cin = 1'b0; sub = 1'b0;
      pend.sum = 20'(i + 17); pend.cout = 1'b0; pend.ovf = 1'b0;
      in_valid = 1'b1;
      cycle(v, t);
      chk("mr_accept", 64'(t), 64'd1);
    end
    cycle(v, t);
    chk("mr_full_blocks", 64'(t), 64'd0);
    in_valid = 1'b0;
    rst = 1'b1;
    cycle(v, t);
    rst = 1'b0;
    q.delete();
    hold_prev = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(v, t);
      if (v) seen++;
    end
    chk("mr_none_emerge", 64'(seen), 64'd0);

    // Parameter sweep: single transactions, latency and result per instance.
    for (int vec = 0; vec < 4; vec++) begin
      if (vec == 0) begin
        sw_a = '1; sw_b = 64'd1; sw_cin = 1'b0; sw_sub = 1'b0;
      end else begin
        sw_a = {$urandom, $urandom}; sw_b = {$urandom, $urandom};
        sw_cin = 1'($urandom); sw_sub = 1'($urandom);
      end
      for (int i = 0; i < NC; i++) chk("sw_in_ready", 64'(sw_ready[i]), 64'd1);
      sw_in_valid = 1'b1;
      @(posedge clk); #1;
      sw_in_valid = 1'b0;
      for (int i = 0; i < NC; i++) begin
        first[i] = -1; c_sum[i] = '0; c_co[i] = 1'b0; c_ov[i] = 1'b0;
      end
      for (int c = 0; c < 20; c++) begin
        for (int i = 0; i < NC; i++) begin
          if (sw_valid[i] && first[i] < 0) begin
            first[i] = c;
            c_sum[i] = sw_sum[i*64 +: 64];
            c_co[i]  = sw_cout[i];
            c_ov[i]  = sw_ovf[i];
          end
        end
        @(posedge clk); #1;
      end
      for (int i = 0; i < NC; i++) begin
        r = model(sw_a, sw_b, sw_cin, sw_sub, cfg_w(i));
        chk($sformatf("sw%0d_latency", i), 64'(first[i]),
            64'(((cfg_w(i) / 4) + cfg_sb(i) - 1) / cfg_sb(i) - 1));
        chk($sformatf("sw%0d_sum", i), c_sum[i], r[63:0]);
        chk($sformatf("sw%0d_cout", i), 64'(c_co[i]), 64'(r[64]));
        chk($sformatf("sw%0d_ovf", i), 64'(c_ov[i]), 64'(r[65]));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipelined_cla_adder.md
# pipelined_cla_adder

Parametrised, pipelined carry look-ahead adder/subtractor. WIDTH is built from 4-bit CLA groups, and a configurable number of groups is evaluated per pipeline stage, with the inter-group carry registered between stages. Operands enter and results leave through valid/ready handshakes, so the block drops into datapaths (for example, the carry-save adder's final carry-propagate stage) at higher clock rates than a single-cycle look-ahead chain allows. Add and subtract are selected per transaction, and signed overflow is reported.

## Interface
- WIDTH, 20, operand/result width; multiple of 4, range 4..64; any other value is an elaboration error
- STAGE_BLOCKS, 2, 4-bit CLA groups per pipeline stage, ≥1; G = WIDTH/4 groups, S = ceil(G/STAGE_BLOCKS) stages
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand transaction present
- in_ready  out  1  block accepts the transaction this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in (add) / borrow-in (sub)
- sub  in  1  0: a+b+cin; 1: a−b−cin
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts the result
- sum  out  WIDTH  result, modulo 2^WIDTH
- cout  out  1  carry-out of MSB (sub: 1 = no borrow)
- overflow  out  1  two's-complement signed overflow

## Operation
- Effective operand B' = sub ? ~b : b; effective carry-in c0 = cin ^ sub. Result = a + B' + c0, so sub computes a − b − cin.
- Group k (bits 4k+3:4k) uses standard 4-bit CLA generate/propagate logic. Within a stage, the STAGE_BLOCKS groups chain carry combinationally. The stage's carry-out is registered and feeds the next stage.
- Skew handling: stage j registers the sum bits completed so far. It also registers the still-unprocessed upper a/B' bits and the sub-derived carry. No bit is recomputed; sum is assembled in order at the final stage.
- overflow = carry into MSB XOR carry out of MSB, computed in the last stage.
- Each stage holds a valid bit. Global advance enable en = ~out_valid | out_ready.
- in_ready = en. The transfer happens when in_valid & in_ready.
- When en=0, every stage register and valid bit holds. There is no internal bubble collapsing.
- When en=1 and in_valid=0, a bubble (valid=0) enters stage 1.
- sum/cout/overflow/out_valid are driven directly from final-stage registers, with no combinational path from inputs.
- Reset (rst=1 at an edge): all valid bits cleared and all data registers cleared. In-flight transactions are discarded, not completed. This applies mid-stream too.

## Timing
- Reset values: out_valid=0, sum=0, cout=0, overflow=0. in_ready=1 during and after reset, but no transfer is recorded at an edge where rst=1.
- Latency: a transaction accepted at edge t appears on outputs after edge t+S−1, i.e. out_valid=1 in the cycle following that edge. S=3 for defaults. STAGE_BLOCKS ≥ G gives S=1.
- Throughput: one transaction per cycle when out_ready stays 1.
- Stall: out_valid=1 & out_ready=0 freezes the whole pipe and drops in_ready the same cycle. Outputs stay stable until accepted.
- Simultaneous accept and release: out_valid=1 & out_ready=1 & in_valid=1 means the result leaves and the new operand enters on the same edge.
- Order is strictly preserved. No duplication or loss except on reset.

## Test plan
- Reset: assert rst for 2 cycles with in_valid=1 → out_valid=0, sum=0, cout=0, overflow=0. After release with in_valid=0, out_valid stays 0.
- Full carry ripple (defaults): a=0xFFFFF, b=0x00001, cin=0, sub=0 accepted at edge t → after edge t+2: sum=0x00000, cout=1, overflow=0.
- Subtract: a=0x00005, b=0x00007, sub=1, cin=0 → sum=0xFFFFE, cout=0, overflow=0. a=0x00007, b=0x00005, sub=1, cin=1 → sum=0x00001, cout=1.
- Signed overflow: a=0x7FFFF, b=0x00001, add → sum=0x80000, cout=0, overflow=1. a=0x80000, b=0x00001, sub=1 → sum=0x7FFFF, overflow=1.
- Stream with backpressure: 16 random operations, with in_valid and out_ready randomised per cycle → outputs match a reference model in order, with none lost or duplicated. Outputs stay stable while out_valid & ~out_ready.
- Parameter sweep and mid-stream reset: WIDTH ∈ {4,8,20,64}, STAGE_BLOCKS ∈ {1,2,G} → latency exactly S and results match the model. Asserting rst with 3 transactions in flight → none emerge afterward.
